// File: rtl/input_conditioner.sv
// Synchronises and debounces N_CH raw switch/button lines into clean levels.
// Optional INCOND_EDGE_EN adds registered one-cycle rise/fall pulses per channel.
module input_conditioner #(
    parameter  int N_CH           = 4,
    parameter  int TICK_DIV       = 1,
    parameter  int DEBOUNCE_TICKS = 4,
    localparam int CNT_W          = $clog2(DEBOUNCE_TICKS + 1)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pending,
    output logic            tick
`ifdef INCOND_EDGE_EN
    ,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
`endif
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [N_CH-1:0]  sync1_q, sync2_q;

    // tick_q is high exactly while the prescaler sits at its last count
    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_d == PRE_LAST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign tick = tick_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             mismatch;

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                level_d  = level_q;
                mismatch = sync2_q[gi] ^ level_q;
                case (state_q)
                    ST_STABLE: begin
                        cnt_d = '0;
                        if (mismatch) begin
                            // The entry edge counts as a qualifying tick when tick is high
                            if (tick_q && (DEBOUNCE_TICKS == 1)) begin
                                level_d = ~level_q;
                            end else if (tick_q) begin
                                state_d = ST_PENDING;
                                cnt_d   = CNT_W'(1);
                            end else begin
                                state_d = ST_PENDING;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (!mismatch) begin
                            state_d = ST_STABLE;
                            cnt_d   = '0;
                        end else if (tick_q) begin
                            if (cnt_q == CNT_LAST) begin
                                level_d = ~level_q;
                                state_d = ST_STABLE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    state_q <= ST_STABLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                end
            end

            assign level[gi]   = level_q;
            assign pending[gi] = (state_q == ST_PENDING);

`ifdef INCOND_EDGE_EN
            logic rise_q, rise_d;
            logic fall_q, fall_d;

            // Pulses line up with the first cycle the new level is visible
            always_comb begin
                rise_d = level_d & ~level_q;
                fall_d = ~level_d & level_q;
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign rise[gi] = rise_q;
            assign fall[gi] = fall_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a default instance and a slow-prescaler instance.
// Stimulus queues expected values per cycle; a negedge monitor pops and compares them.
module tb_input_conditioner;

    logic       clk;
    logic       nrst;
    logic [3:0] raw_a, raw_b;
    logic [3:0] level_a, pend_a, level_b, pend_b;
    logic       tick_a, tick_b;
`ifdef INCOND_EDGE_EN
    logic [3:0] rise_a, fall_a, rise_b, fall_b;
`endif

    input_conditioner u_dut_a (
        .clk     (clk),
        .nrst    (nrst),
        .raw_in  (raw_a),
        .level   (level_a),
        .pending (pend_a),
        .tick    (tick_a)
`ifdef INCOND_EDGE_EN
        ,
        .rise    (rise_a),
        .fall    (fall_a)
`endif
    );

    input_conditioner #(
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (2)
    ) u_dut_b (
        .clk     (clk),
        .nrst    (nrst),
        .raw_in  (raw_b),
        .level   (level_b),
        .pending (pend_b),
        .tick    (tick_b)
`ifdef INCOND_EDGE_EN
        ,
        .rise    (rise_b),
        .fall    (fall_b)
`endif
    );

    typedef struct {
        int         cyc;
        int         dut;
        string      name;
        logic [3:0] level;
        logic [3:0] pend;
        bit         cp;
        logic       tick;
        bit         ct;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input int dut, input string nm,
                        input logic [3:0] lv, input logic [3:0] pd, input bit cp,
                        input logic tk, input bit ct,
                        input logic [3:0] rs, input logic [3:0] fl);
        exp_t e;
        e.cyc = at;  e.dut = dut; e.name = nm;
        e.level = lv; e.pend = pd; e.cp = cp;
        e.tick = tk; e.ct = ct; e.rise = rs; e.fall = fl;
        exp_q.push_back(e);
    endtask

    task automatic chk_a(input int at, input string nm, input logic [3:0] lv,
                         input logic [3:0] pd, input logic [3:0] rs, input logic [3:0] fl);
        push(at, 0, nm, lv, pd, 1'b1, 1'b1, 1'b1, rs, fl);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t       e;
            logic [3:0] lv, pd, rs, fl;
            logic       tk;
            bit         bad;
            e  = exp_q.pop_front();
            lv = (e.dut == 0) ? level_a : level_b;
            pd = (e.dut == 0) ? pend_a  : pend_b;
            tk = (e.dut == 0) ? tick_a  : tick_b;
            rs = e.rise;
            fl = e.fall;
`ifdef INCOND_EDGE_EN
            rs = (e.dut == 0) ? rise_a : rise_b;
            fl = (e.dut == 0) ? fall_a : fall_b;
`endif
            total++;
            bad = (e.cyc != cyc) || (lv !== e.level) ||
                  (e.cp && (pd !== e.pend)) || (e.ct && (tk !== e.tick));
`ifdef INCOND_EDGE_EN
            if (e.dut == 0 && ((rs !== e.rise) || (fl !== e.fall))) bad = 1'b1;
`endif
            if (bad) begin
                $display("FAIL %s dut%0d cyc=%0d (due %0d): got level=%b pending=%b tick=%b rise=%b fall=%b, want level=%b pending=%b tick=%b rise=%b fall=%b",
                         e.name, e.dut, cyc, e.cyc, lv, pd, tk, rs, fl,
                         e.level, e.pend, e.tick, e.rise, e.fall);
            end else begin
                passed++;
                $display("check %-14s dut%0d cyc=%0d level=%b pending=%b tick=%b ok",
                         e.name, e.dut, cyc, lv, pd, tk);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at cyc=%0d, want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        nrst  = 1'b0;
        raw_a = 4'b0000;
        raw_b = 4'b0000;
        push(2, 0, "reset_a", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        push(2, 1, "reset_b", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        wait_cyc(3);
        nrst = 1'b1;

        // Prescaler: TICK_DIV=4, DEBOUNCE_TICKS=2 on instance B
        c     = cyc;
        raw_b = 4'b0100;
        push(c,     0, "tick_pre",   4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        push(c + 1, 0, "tick_first", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        push(c + 2, 1, "pre_sync",   4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        push(c + 3, 1, "pre_enter",  4'b0000, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        push(c + 4, 1, "pre_tick1",  4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        push(c + 7, 1, "pre_wait",   4'b0000, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        push(c + 8, 1, "pre_toggle", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000);
        wait_cyc(10);

        // Clean step on channel 0
        c     = cyc;
        raw_a = 4'b0001;
        chk_a(c + 2, "step_sync",  4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk_a(c + 3, "step_pend",  4'b0000, 4'b0001, 4'b0000, 4'b0000);
        chk_a(c + 5, "step_hold",  4'b0000, 4'b0001, 4'b0000, 4'b0000);
        chk_a(c + 6, "step_level", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        chk_a(c + 7, "step_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(10);

        // Three-cycle glitch on channel 1
        c     = cyc;
        raw_a = 4'b0011;
        chk_a(c + 3, "glitch_pend", 4'b0001, 4'b0010, 4'b0000, 4'b0000);
        chk_a(c + 5, "glitch_hold", 4'b0001, 4'b0010, 4'b0000, 4'b0000);
        chk_a(c + 6, "glitch_drop", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        chk_a(c + 9, "glitch_keep", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(3);
        raw_a = 4'b0001;
        wait_cyc(9);

        // Sustained change on channel 1 needs the full count again
        c     = cyc;
        raw_a = 4'b0011;
        chk_a(c + 5, "recnt_hold", 4'b0001, 4'b0010, 4'b0000, 4'b0000);
        chk_a(c + 6, "recnt_lvl",  4'b0011, 4'b0000, 4'b0010, 4'b0000);
        wait_cyc(10);

        // Both channels fall
        c     = cyc;
        raw_a = 4'b0000;
        chk_a(c + 5, "fall_hold",  4'b0011, 4'b0011, 4'b0000, 4'b0000);
        chk_a(c + 6, "fall_lvl",   4'b0000, 4'b0000, 4'b0000, 4'b0011);
        chk_a(c + 7, "fall_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(10);

        // Multi-channel simultaneous change
        c     = cyc;
        raw_a = 4'b1010;
        chk_a(c + 5, "multi_hold", 4'b0000, 4'b1010, 4'b0000, 4'b0000);
        chk_a(c + 6, "multi_lvl",  4'b1010, 4'b0000, 4'b1010, 4'b0000);
        wait_cyc(8);

        // Channel 3 bounces every cycle; level must hold
        for (int i = 0; i < 20; i++) begin
            raw_a = (i % 2 == 1) ? 4'b1010 : 4'b0010;
            push(cyc, 0, "bounce", 4'b1010, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
            wait_cyc(1);
        end
        raw_a = 4'b1010;
        chk_a(cyc + 4, "bounce_settle", 4'b1010, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(6);

        // Async reset with channel 0 pending at count 2
        c     = cyc;
        raw_a = 4'b1011;
        chk_a(c + 3, "rst_pend", 4'b1010, 4'b0001, 4'b0000, 4'b0000);
        push(c + 4, 0, "rst_async_a", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        push(c + 4, 1, "rst_async_b", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        wait_cyc(4);
        nrst  = 1'b0;
        raw_a = 4'b0000;
        wait_cyc(2);
        nrst  = 1'b1;
        c     = cyc;
        raw_a = 4'b0001;
        push(c, 0, "rel_tick0", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        chk_a(c + 1, "rel_tick1",   4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk_a(c + 3, "rel_pend",    4'b0000, 4'b0001, 4'b0000, 4'b0000);
        chk_a(c + 5, "rel_clear",   4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk_a(c + 8, "rel_nolevel", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(2);
        raw_a = 4'b0000;
        wait_cyc(10);

        if (exp_q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations unchecked, want 0", exp_q.size());
            total += exp_q.size();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front end for the lab FSM's i0..i3 inputs: takes N_CH asynchronous raw switch/button lines and delivers clean, synchronous, debounced levels.
- Per channel: 2-flop synchronizer, then a debounce state machine clocked by a shared prescaler tick.
- level[3:0] drives the FSM's i3..i0 directly; optional edge pulses serve single-step use.

Parameters:
- N_CH, 4, number of channels.
- TICK_DIV, 1, prescaler divide ratio; one tick every TICK_DIV clk cycles; legal range >=1.
- DEBOUNCE_TICKS, 4, consecutive qualifying ticks needed to accept a new level; legal range >=1.
- CNT_W, $clog2(DEBOUNCE_TICKS+1), debounce counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- raw_in  input  N_CH  asynchronous raw lines.
- level  output  N_CH  debounced level, registered.
- pending  output  N_CH  1 while channel is in PENDING, registered.
- tick  output  1  prescaler tick, registered, for bench observation.

Behaviour:
- Reset (nrst=0, async): sync flops, level, pending, counters and prescaler all clear to 0. tick=0. Reset mid-count discards the count; no partial state survives.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle when the counter equals TICK_DIV-1.
  - TICK_DIV=1 makes tick constantly 1 after the first post-reset edge.
- Synchronizer: sync1<=raw_in, sync2<=sync1. Only sync2 is used downstream.
- Per-channel FSM, states STABLE and PENDING:
  - STABLE, sync2==level: counter=0, pending=0.
  - STABLE -> PENDING on the edge where sync2!=level:
    - pending goes to 1.
    - If tick is also 1 on that edge, the counter loads 1; otherwise it loads 0.
  - PENDING, sync2!=level, tick=1:
    - If counter==DEBOUNCE_TICKS-1: level toggles, counter->0, state->STABLE, pending->0, all on the same edge.
    - Otherwise the counter increments.
  - PENDING, sync2!=level, tick=0: hold.
  - PENDING, sync2==level (glitch): counter->0, state->STABLE, pending->0; level unchanged.
  - DEBOUNCE_TICKS=1: level toggles on the first qualifying tick edge. If that tick coincides with entry from STABLE, the toggle happens on that entry edge.
- Latency with TICK_DIV=1:
  - A raw change settled before edge 1 appears on level at edge DEBOUNCE_TICKS+2. Default: edge 6.
  - General case: 2 edges plus DEBOUNCE_TICKS ticks, with up to TICK_DIV-1 extra edges of tick-phase uncertainty.
- Channels are independent. Simultaneous changes on several channels resolve individually.
- The counter never exceeds DEBOUNCE_TICKS-1, so no wrap is possible.

Optional Feature:
- Macro: INCOND_EDGE_EN.
- Defined:
  - Adds output ports rise[N_CH] and fall[N_CH], registered.
  - rise[n]=1 for exactly one cycle, in the cycle level[n] first reads 1 after a 0->1 toggle.
  - fall[n] is the same for a 1->0 toggle.
  - Both read 0 during and immediately after reset.
- Not defined: rise and fall ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert nrst=0 mid-PENDING with counter=2 -> level, pending and tick read 0 immediately (async); after release, a 2-cycle raw high yields no toggle.
- Clean step, TICK_DIV=1, DEBOUNCE_TICKS=4: raw_in[0] 0->1 before edge 1 -> pending[0]=1 after edge 3; level[0]=1 after edge 6; pending[0]=0 after edge 6.
- Glitch: raw_in[1] high for 3 cycles then low, defaults -> pending[1] pulses, level[1] stays 0, counter back to 0.
- Prescaler, TICK_DIV=4, DEBOUNCE_TICKS=2: tick period is 4 cycles; steady raw_in[2]=1 -> level[2] toggles on the 2nd tick edge after the sync2 mismatch.
- Multi-channel: raw_in 0000->1010 at once -> level reads 1010 on the same edge; then raw_in[3] bounces 1/0 every cycle for 20 cycles -> level[3] stays 1.
- INCOND_EDGE_EN defined: 0->1 then 1->0 on raw_in[0] -> one rise[0] pulse coincident with level 0->1 and one fall[0] pulse with level 1->0; no other pulses.
